snoop_responder: RTL and testbench

SNOOP_RESPONDER -- requirements
Module: snoop_responder

---
 rtl/snoop_responder.sv | 182 ++++++++++++++++++
 tb/tb_snoop_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// Snoop responder: queues bus snoop requests, looks up the MESI tag state, returns
// NOHIT/HIT/HITM with a tag-state update, and holds off for a modified-line writeback.
package mypkg;
  localparam logic [1:0] NOHIT = 2'd0;
  localparam logic [1:0] HIT   = 2'd1;
  localparam logic [1:0] HITM  = 2'd2;
endpackage

module snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MODE     = 0,
  parameter int protocol = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       snp_valid,
  output logic                       snp_ready,
  input  logic [1:0]                 snp_op,
  input  logic [ADDR_W-1:0]          snp_addr,
  output logic                       lk_valid,
  output logic [ADDR_W-1:0]          lk_addr,
  input  logic [protocol-1:0]        lk_state,
  output logic                       res_valid,
  output logic [protocol-1:0]        snoop_result,
  output logic                       upd_valid,
  output logic [protocol-1:0]        upd_state,
  output logic                       wb_req,
  output logic [ADDR_W-1:0]          wb_addr,
  input  logic                       wb_ack,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count
);
  import mypkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV = 2'd3;

  localparam logic [protocol-1:0] ST_I = protocol'(0);
  localparam logic [protocol-1:0] ST_S = protocol'(1);
  localparam logic [protocol-1:0] ST_E = protocol'(2);
  localparam logic [protocol-1:0] ST_M = protocol'(3);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WB} state_t;

  state_t                r_state;
  logic [1:0]            r_op_mem   [DEPTH];
  logic [ADDR_W-1:0]     r_addr_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_hold_op;
  logic [ADDR_W-1:0]     r_hold_addr;

  logic                  w_push;
  logic                  w_pop;
  logic [protocol-1:0]   w_res;
  logic                  w_upd_v;
  logic [protocol-1:0]   w_upd_st;
  logic                  w_err;

  assign snp_ready = (r_count != CW'(DEPTH));
  assign count     = r_count;
  assign w_push    = snp_valid && snp_ready;
  assign w_pop     = (r_state == IDLE) && (r_count != '0);
  assign lk_addr   = r_hold_addr;
  assign wb_addr   = r_hold_addr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wptr]   <= snp_op;
      r_addr_mem[r_wptr] <= snp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result/update decision from the held request and the same-cycle tag state
  always_comb begin
    w_res    = protocol'(NOHIT);
    w_upd_v  = 1'b0;
    w_upd_st = lk_state;
    w_err    = 1'b0;
    if (MODE == 1) begin
      case (r_hold_addr[1:0])
        2'b00:   w_res = protocol'(HIT);
        2'b01:   w_res = protocol'(HITM);
        default: w_res = protocol'(NOHIT);
      endcase
    end else if (r_hold_op != OP_WRITE) begin
      case (lk_state)
        ST_S: begin
          w_res = protocol'(HIT);
          if (r_hold_op != OP_READ) begin
            w_upd_v  = 1'b1;
            w_upd_st = ST_I;
          end
        end
        ST_E, ST_M: begin
          if (r_hold_op == OP_INV) begin
            w_err = 1'b1;
          end else begin
            w_res    = (lk_state == ST_M) ? protocol'(HITM) : protocol'(HIT);
            w_upd_v  = 1'b1;
            w_upd_st = (r_hold_op == OP_READ) ? ST_S : ST_I;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      lk_valid     <= 1'b0;
      res_valid    <= 1'b0;
      snoop_result <= protocol'(NOHIT);
      upd_valid    <= 1'b0;
      wb_req       <= 1'b0;
      err          <= 1'b0;
    end else begin
      res_valid    <= 1'b0;
      upd_valid    <= 1'b0;
      snoop_result <= protocol'(NOHIT);
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold_op   <= r_op_mem[r_rptr];
            r_hold_addr <= r_addr_mem[r_rptr];
            lk_valid    <= (MODE == 0);
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          lk_valid     <= 1'b0;
          res_valid    <= 1'b1;
          snoop_result <= w_res;
          if (w_upd_v) begin
            upd_valid <= 1'b1;
            upd_state <= w_upd_st;
          end
          if (w_err) err <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if ((MODE == 0) && (snoop_result == protocol'(HITM))) begin
            wb_req  <= 1'b1;
            r_state <= WB;
          end else begin
            r_state <= IDLE;
          end
        end
        WB: begin
          if (wb_ack) begin
            wb_req  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: a MESI-lookup instance and an address-LSB debug instance.
module tb_snoop_responder;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, RW = 2'd2, IV = 2'd3;
  localparam logic [1:0] NH = 2'd0, HT = 2'd1, HM = 2'd2;
  localparam logic [1:0] SI = 2'd0, SS = 2'd1, SE = 2'd2, SM = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0, rdy0, lkv0, resv0, updv0, wbr0, wack0, err0;
  logic [1:0]  op0, lks0, res0, upds0;
  logic [31:0] a0, lka0, wba0;
  logic [2:0]  cnt0;

  logic        v1, rdy1, lkv1, resv1, updv1, wbr1, err1;
  logic [1:0]  res1, upds1;
  logic [31:0] a1, lka1, wba1;
  logic [2:0]  cnt1;

  snoop_responder #(.ADDR_W(32), .DEPTH(4), .MODE(0), .protocol(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .snp_valid(v0), .snp_ready(rdy0), .snp_op(op0), .snp_addr(a0),
    .lk_valid(lkv0), .lk_addr(lka0), .lk_state(lks0), .res_valid(resv0), .snoop_result(res0),
    .upd_valid(updv0), .upd_state(upds0), .wb_req(wbr0), .wb_addr(wba0), .wb_ack(wack0),
    .err(err0), .count(cnt0));

  snoop_responder #(.ADDR_W(32), .DEPTH(4), .MODE(1), .protocol(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .snp_valid(v1), .snp_ready(rdy1), .snp_op(RD), .snp_addr(a1),
    .lk_valid(lkv1), .lk_addr(lka1), .lk_state(SM), .res_valid(resv1), .snoop_result(res1),
    .upd_valid(updv1), .upd_state(upds1), .wb_req(wbr1), .wb_addr(wba1), .wb_ack(1'b0),
    .err(err1), .count(cnt1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [1:0] op, input logic [31:0] addr);
    v0 = 1'b1; op0 = op; a0 = addr;
    tick();
    v0 = 1'b0;
  endtask

  task automatic run_one(input logic [1:0] op, input logic [1:0] st, input logic [31:0] addr,
                         input logic [1:0] er, input logic eu, input logic [1:0] es);
    lks0 = st;
    send0(op, addr);
    chk("cnt_acc", cnt0, 1);
    tick();
    chk("lk_valid", lkv0, 1);
    chk("lk_addr", lka0, addr);
    tick();
    chk("res_valid", resv0, 1);
    chk("result", res0, er);
    chk("upd_valid", updv0, eu);
    if (eu) chk("upd_state", upds0, es);
    tick();
    chk("res_drop", resv0, 0);
    chk("res_idle", res0, NH);
    chk("upd_drop", updv0, 0);
    chk("wb_req", wbr0, er == HM);
    if (er == HM) begin
      chk("wb_addr", wba0, addr);
      tick();
      tick();
      chk("wb_hold", wbr0, 1);
      wack0 = 1'b1;
      tick();
      wack0 = 1'b0;
      chk("wb_done", wbr0, 0);
    end
  endtask

  task automatic wait_res(input logic [31:0] addr);
    bit ok = 0;
    for (int c = 0; c < 12; c++) begin
      if (resv0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("res_seen", ok, 1);
    chk("order_addr", lka0, addr);
    tick();
  endtask

  task automatic stall_in_wb(input logic [31:0] addr);
    lks0 = SM;
    send0(RD, addr);
    tick();
    tick();
    tick();
    chk("stall_wb", wbr0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0] m1_exp [4];
    int seen;
    m1_exp[0] = HT; m1_exp[1] = HM; m1_exp[2] = NH; m1_exp[3] = NH;
    rst_n = 1'b0; v0 = 1'b0; op0 = RD; a0 = '0; lks0 = SI; wack0 = 1'b0;
    v1 = 1'b0; a1 = '0;
    tick();
    tick();
    chk("rst_cnt", cnt0, 0);
    chk("rst_rdy", rdy0, 1);
    chk("rst_res", {resv0, res0}, 0);
    chk("rst_ctl", {lkv0, updv0, wbr0, err0}, 0);
    rst_n = 1'b1;
    tick();

    // Debug-mode instance: result from address LSBs
    for (int k = 0; k < 4; k++) begin
      v1 = 1'b1; a1 = 32'h1000 | k;
      tick();
      v1 = 1'b0;
      tick();
      chk("m1_lkv", lkv1, 0);
      tick();
      chk("m1_resv", resv1, 1);
      chk("m1_res", res1, m1_exp[k]);
      chk("m1_upd", updv1, 0);
      tick();
      chk("m1_wb", wbr1, 0);
    end

    run_one(RD, SM, 32'h100, HM, 1, SS);
    run_one(RW, SS, 32'h200, HT, 1, SI);
    run_one(RD, SS, 32'h204, HT, 0, SS);
    run_one(RD, SE, 32'h208, HT, 1, SS);
    run_one(RW, SE, 32'h20C, HT, 1, SI);
    run_one(RW, SM, 32'h210, HM, 1, SI);
    run_one(RD, SI, 32'h214, NH, 0, SI);
    run_one(WR, SM, 32'h218, NH, 0, SI);
    run_one(IV, SS, 32'h21C, HT, 1, SI);
    chk("err_clear", err0, 0);
    run_one(IV, SE, 32'h220, NH, 0, SI);
    chk("err_set", err0, 1);

    wack0 = 1'b1;
    tick();
    wack0 = 1'b0;
    chk("stray_ack", {wbr0, resv0}, 0);

    // Fill while the FSM waits for a writeback
    stall_in_wb(32'h300);
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; op0 = RD; a0 = 32'h400 + i;
      tick();
    end
    v0 = 1'b0;
    chk("full_cnt", cnt0, 4);
    chk("full_rdy", rdy0, 0);
    lks0 = SS;
    wack0 = 1'b1;
    tick();
    wack0 = 1'b0;
    for (int k = 0; k < 4; k++) wait_res(32'h400 + k);
    chk("err_sticky", err0, 1);

    // Push and pop on the same edge at count 2
    stall_in_wb(32'h4F0);
    v0 = 1'b1; a0 = 32'h500;
    tick();
    a0 = 32'h501;
    tick();
    v0 = 1'b0;
    chk("two_cnt", cnt0, 2);
    lks0 = SS;
    wack0 = 1'b1;
    tick();
    wack0 = 1'b0;
    v0 = 1'b1; a0 = 32'h502;
    tick();
    v0 = 1'b0;
    chk("pushpop_cnt", cnt0, 2);
    for (int k = 0; k < 3; k++) wait_res(32'h500 + k);

    // Reset during writeback with two requests queued
    stall_in_wb(32'h600);
    v0 = 1'b1; a0 = 32'h700;
    tick();
    a0 = 32'h701;
    tick();
    v0 = 1'b0;
    chk("q_cnt", cnt0, 2);
    rst_n = 1'b0;
    tick();
    chk("rst_wb", wbr0, 0);
    chk("rst_cnt2", cnt0, 0);
    chk("rst_rdy2", rdy0, 1);
    chk("rst_err", err0, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (resv0 || lkv0) seen++;
    end
    chk("no_resp_after_rst", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
